// File: rtl/native_bus_arbiter.sv
// Round-robin arbiter sharing one native-bus memory port between NUM_REQ masters.
// One transaction in flight at a time; a watchdog aborts transactions whose slave never answers.
module native_bus_arbiter #(
  parameter int          NUM_REQ        = 2,
  parameter int          ADDRESS_WIDTH  = 16,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF,
  localparam int         GW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_address_i,
  input  logic [NUM_REQ*32-1:0]      req_data_i,
  input  logic [NUM_REQ*4-1:0]       req_strb_i,
  output logic [NUM_REQ-1:0]         req_ack_o,
  output logic [31:0]                req_data_o,
  output logic [ADDRESS_WIDTH-1:0]   mem_address_o,
  output logic [31:0]                mem_data_o,
  output logic [3:0]                 mem_strb_o,
  output logic                       mem_valid_o,
  input  logic [31:0]                mem_data_i,
  input  logic                       mem_valid_i,
  output logic [GW-1:0]              grant_o,
  output logic                       busy_o,
  output logic                       timeout_o
);

  localparam int             WDW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit             WD_EN    = (TIMEOUT_CYCLES > 0);
  localparam logic [WDW-1:0] WD_LAST  = WDW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [GW-1:0]  LAST_IDX = GW'(NUM_REQ - 1);

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_e;

  state_e                   state_q, state_d;
  logic [GW-1:0]            ptr_q, ptr_d;
  logic [GW-1:0]            grant_q, grant_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]              mem_data_q, mem_data_d;
  logic [3:0]               mem_strb_q, mem_strb_d;
  logic                     mem_valid_q, mem_valid_d;
  logic [NUM_REQ-1:0]       req_ack_q, req_ack_d;
  logic [31:0]              req_data_q, req_data_d;
  logic                     timeout_q, timeout_d;
  logic [WDW-1:0]           wdog_q, wdog_d;

  logic [ADDRESS_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [31:0]              data_arr [NUM_REQ];
  logic [3:0]               strb_arr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign addr_arr[k] = req_address_i[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign data_arr[k] = req_data_i[k*32 +: 32];
    assign strb_arr[k] = req_strb_i[k*4 +: 4];
  end

  // A requester acked last cycle is masked so it cannot be re-granted on a stale request.
  logic [NUM_REQ-1:0] eligible;
  logic               pick_valid;
  logic [GW-1:0]      pick_idx;

  assign eligible = req_valid_i & ~req_ack_q;

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    // Walk from the farthest offset to the nearest so the closest set bit after the pointer wins.
    for (int off = NUM_REQ; off >= 1; off--) begin
      if (eligible[(int'(ptr_q) + off) % NUM_REQ]) begin
        pick_valid = 1'b1;
        pick_idx   = GW'((int'(ptr_q) + off) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_strb_d  = mem_strb_q;
    mem_valid_d = mem_valid_q;
    req_ack_d   = '0;
    req_data_d  = req_data_q;
    timeout_d   = 1'b0;
    wdog_d      = wdog_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          ptr_d       = pick_idx;
          grant_d     = pick_idx;
          mem_addr_d  = addr_arr[pick_idx];
          mem_data_d  = data_arr[pick_idx];
          mem_strb_d  = strb_arr[pick_idx];
          mem_valid_d = 1'b1;
          wdog_d      = '0;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // A slave response on the expiry cycle takes priority over the abort.
        if (mem_valid_i) begin
          mem_valid_d        = 1'b0;
          req_data_d         = mem_data_i;
          req_ack_d[grant_q] = 1'b1;
          state_d            = ST_IDLE;
        end else if (WD_EN && (wdog_q == WD_LAST)) begin
          mem_valid_d        = 1'b0;
          req_data_d         = TIMEOUT_DATA;
          req_ack_d[grant_q] = 1'b1;
          timeout_d          = 1'b1;
          state_d            = ST_IDLE;
        end else if (WD_EN) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= ST_IDLE;
      ptr_q       <= LAST_IDX;
      grant_q     <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_strb_q  <= '0;
      mem_valid_q <= 1'b0;
      req_ack_q   <= '0;
      req_data_q  <= '0;
      timeout_q   <= 1'b0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_strb_q  <= mem_strb_d;
      mem_valid_q <= mem_valid_d;
      req_ack_q   <= req_ack_d;
      req_data_q  <= req_data_d;
      timeout_q   <= timeout_d;
      wdog_q      <= wdog_d;
    end
  end

  assign req_ack_o     = req_ack_q;
  assign req_data_o    = req_data_q;
  assign mem_address_o = mem_addr_q;
  assign mem_data_o    = mem_data_q;
  assign mem_strb_o    = mem_strb_q;
  assign mem_valid_o   = mem_valid_q;
  assign grant_o       = grant_q;
  assign busy_o        = (state_q == ST_BUSY);
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_native_bus_arbiter.sv
// Directed bench for native_bus_arbiter: 4 requesters, 8-cycle watchdog.
// Covers reset, read, write, rotation, timeout, response/timeout race and reset mid-transaction.
module tb_native_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;

  logic              clk_i = 1'b0;
  logic              reset_ni;
  logic [N-1:0]      req_valid_i;
  logic [N*AW-1:0]   req_address_i;
  logic [N*32-1:0]   req_data_i;
  logic [N*4-1:0]    req_strb_i;
  logic [N-1:0]      req_ack_o;
  logic [31:0]       req_data_o;
  logic [AW-1:0]     mem_address_o;
  logic [31:0]       mem_data_o;
  logic [3:0]        mem_strb_o;
  logic              mem_valid_o;
  logic [31:0]       mem_data_i;
  logic              mem_valid_i;
  logic [1:0]        grant_o;
  logic              busy_o;
  logic              timeout_o;

  int n_checks = 0;
  int n_fail   = 0;

  native_bus_arbiter #(
    .NUM_REQ       (N),
    .ADDRESS_WIDTH (AW),
    .TIMEOUT_CYCLES(8),
    .TIMEOUT_DATA  (32'hDEADBEEF)
  ) dut (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .req_valid_i  (req_valid_i),
    .req_address_i(req_address_i),
    .req_data_i   (req_data_i),
    .req_strb_i   (req_strb_i),
    .req_ack_o    (req_ack_o),
    .req_data_o   (req_data_o),
    .mem_address_o(mem_address_o),
    .mem_data_o   (mem_data_o),
    .mem_strb_o   (mem_strb_o),
    .mem_valid_o  (mem_valid_o),
    .mem_data_i   (mem_data_i),
    .mem_valid_i  (mem_valid_i),
    .grant_o      (grant_o),
    .busy_o       (busy_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    req_address_i[k*AW +: AW] = a;
    req_data_i[k*32 +: 32]    = d;
    req_strb_i[k*4 +: 4]      = s;
    req_valid_i[k]            = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset_ni      = 1'b0;
    req_valid_i   = '0;
    req_address_i = '0;
    req_data_i    = '0;
    req_strb_i    = '0;
    mem_data_i    = '0;
    mem_valid_i   = 1'b0;
    tick();
    tick();
    check("rst_mem_valid", 32'(mem_valid_o), 0);
    check("rst_ack",       32'(req_ack_o),   0);
    check("rst_busy",      32'(busy_o),      0);
    check("rst_grant",     32'(grant_o),     0);
    check("rst_timeout",   32'(timeout_o),   0);
    check("rst_rdata",     req_data_o,       0);
    reset_ni = 1'b1;

    // Single read from requester 0
    set_req(0, 16'h0040, 32'h0, 4'b0000);
    tick();
    check("rd_mem_valid", 32'(mem_valid_o),   1);
    check("rd_addr",      32'(mem_address_o), 32'h40);
    check("rd_strb",      32'(mem_strb_o),    0);
    check("rd_grant",     32'(grant_o),       0);
    mem_valid_i = 1'b1;
    mem_data_i  = 32'h12345678;
    tick();
    check("rd_ack",       32'(req_ack_o),   32'b0001);
    check("rd_rdata",     req_data_o,       32'h12345678);
    check("rd_mem_drop",  32'(mem_valid_o), 0);
    mem_valid_i = 1'b0;
    req_valid_i = '0;
    tick();
    check("rd_ack_pulse", 32'(req_ack_o),   0);
    check("rd_rdata_hold", req_data_o,      32'h12345678);
    check("rd_idle",      32'(busy_o),      0);

    // Write from requester 1, inputs changed while busy must be ignored
    set_req(1, 16'h0100, 32'hA5A5A5A5, 4'b0011);
    tick();
    check("wr_grant", 32'(grant_o),       1);
    check("wr_addr",  32'(mem_address_o), 32'h100);
    check("wr_data",  mem_data_o,         32'hA5A5A5A5);
    check("wr_strb",  32'(mem_strb_o),    32'b0011);
    req_address_i[1*AW +: AW] = 16'h0200;
    req_data_i[1*32 +: 32]    = 32'h0;
    req_strb_i[1*4 +: 4]      = 4'b1111;
    tick();
    check("wr_addr_held", 32'(mem_address_o), 32'h100);
    check("wr_data_held", mem_data_o,         32'hA5A5A5A5);
    check("wr_strb_held", 32'(mem_strb_o),    32'b0011);
    mem_valid_i = 1'b1;
    mem_data_i  = 32'h0BADF00D;
    tick();
    check("wr_ack",   32'(req_ack_o), 32'b0010);
    check("wr_rdata", req_data_o,     32'h0BADF00D);
    mem_valid_i = 1'b0;
    req_valid_i = '0;
    tick();
    check("wr_ack_pulse", 32'(req_ack_o), 0);

    // Contention: all valid from reset, grants rotate 0,1,2,3,0
    reset_ni = 1'b0;
    for (int k = 0; k < N; k++) set_req(k, 16'((k + 1) * 16), 32'h0, 4'b0000);
    tick();
    tick();
    reset_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("rr_grant_%0d", i), 32'(grant_o),       32'(i % N));
      check($sformatf("rr_addr_%0d", i),  32'(mem_address_o), 32'(((i % N) + 1) * 16));
      mem_valid_i = 1'b1;
      mem_data_i  = 32'h100 + 32'(i);
      tick();
      check($sformatf("rr_ack_%0d", i),   32'(req_ack_o), 32'(1 << (i % N)));
      check($sformatf("rr_rdata_%0d", i), req_data_o,     32'h100 + 32'(i));
      mem_valid_i = 1'b0;
    end
    req_valid_i = '0;
    tick();

    // Timeout: slave never answers requester 2
    set_req(2, 16'h0300, 32'h0, 4'b0000);
    tick();
    check("to_grant", 32'(grant_o), 2);
    for (int j = 1; j < 8; j++) begin
      tick();
      check($sformatf("to_wait_valid_%0d", j), 32'(mem_valid_o), 1);
      check($sformatf("to_wait_flag_%0d", j),  32'(timeout_o),   0);
    end
    tick();
    check("to_flag",      32'(timeout_o),   1);
    check("to_ack",       32'(req_ack_o),   32'b0100);
    check("to_rdata",     req_data_o,       32'hDEADBEEF);
    check("to_mem_valid", 32'(mem_valid_o), 0);
    req_valid_i = '0;
    tick();
    check("to_flag_pulse", 32'(timeout_o), 0);
    check("to_ack_pulse",  32'(req_ack_o), 0);

    // Race: response arrives on the expiry cycle
    set_req(3, 16'h0400, 32'h0, 4'b0000);
    tick();
    check("race_grant", 32'(grant_o), 3);
    for (int j = 1; j < 8; j++) tick();
    mem_valid_i = 1'b1;
    mem_data_i  = 32'hCAFEF00D;
    tick();
    check("race_ack",   32'(req_ack_o), 32'b1000);
    check("race_flag",  32'(timeout_o), 0);
    check("race_rdata", req_data_o,     32'hCAFEF00D);
    mem_valid_i = 1'b0;
    req_valid_i = '0;
    tick();

    // Reset while busy, then stray response and fresh arbitration
    set_req(1, 16'h0500, 32'h0, 4'b0000);
    tick();
    check("mr_busy", 32'(busy_o), 1);
    #2;
    reset_ni    = 1'b0;
    req_valid_i = '0;
    #1;
    check("mr_mem_valid", 32'(mem_valid_o),   0);
    check("mr_busy_rst",  32'(busy_o),        0);
    check("mr_grant",     32'(grant_o),       0);
    check("mr_addr",      32'(mem_address_o), 0);
    check("mr_rdata",     req_data_o,         0);
    tick();
    reset_ni    = 1'b1;
    mem_valid_i = 1'b1;
    mem_data_i  = 32'h77777777;
    tick();
    check("mr_stray_ack",  32'(req_ack_o), 0);
    check("mr_stray_busy", 32'(busy_o),    0);
    mem_valid_i = 1'b0;
    set_req(0, 16'h0600, 32'h0, 4'b0000);
    set_req(2, 16'h0700, 32'h0, 4'b0000);
    tick();
    check("mr_next_grant", 32'(grant_o),       0);
    check("mr_next_addr",  32'(mem_address_o), 32'h600);
    mem_valid_i = 1'b1;
    mem_data_i  = 32'h11112222;
    tick();
    check("mr_next_ack", 32'(req_ack_o), 32'b0001);
    mem_valid_i = 1'b0;
    req_valid_i = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
